// File: rtl/banco_fifos_pkg.sv
// Shared widths and constants for the banco_fifos queue bank.
// Defaults match the arbiter-side integration: 4 queues of 7 bytes each.
// capacity() gives the usable depth of a queue; one pointer slot stays unused.
package banco_fifos_pkg;

  localparam int QUEUE_QUANTITY_DEF = 4;
  localparam int DATA_BITS_DEF      = 8;
  localparam int BUF_WIDTH_DEF      = 3;
  localparam int ALMOST_FULL_DEF    = 6;

  // Usable words per queue for a given pointer width.
  function automatic int capacity(input int buf_width);
    return (1 << buf_width) - 1;
  endfunction

endpackage

// File: rtl/banco_fifos_fifo_cola.sv
// One queue of the bank: storage, pointers, occupancy, status and sticky error flags.
// Latency: read word is mem[rptr] combinationally; the top registers it on a valid pop.
// Backpressure: push is dropped when full unless popped the same cycle; pops on empty are flagged.
module fifo_cola
  import banco_fifos_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int BUF_WIDTH   = BUF_WIDTH_DEF,
  parameter int ALMOST_FULL = ALMOST_FULL_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enb,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop_hit,
  output logic [DATA_BITS-1:0] rd_dat,
  output logic                 rd_vld,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic [BUF_WIDTH-1:0] count,
  output logic                 err_overflow,
  output logic                 err_underflow
);

  localparam int DEPTH = 1 << BUF_WIDTH;
  localparam logic [BUF_WIDTH-1:0] CAP = BUF_WIDTH'(capacity(BUF_WIDTH));

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [BUF_WIDTH-1:0] wptr;
  logic [BUF_WIDTH-1:0] rptr;
  logic                 wr;
  logic                 rd;

  // A full queue still accepts a push when the same cycle pops it.
  assign wr          = push & (~full | pop_hit);
  assign rd          = pop_hit & ~empty;
  assign empty       = (count == '0);
  assign full        = (count == CAP);
  assign almost_full = (int'(count) >= ALMOST_FULL);
  assign rd_dat      = mem[rptr];
  assign rd_vld      = rd;

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (enb) begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      if (wr && !rd)      count <= count + 1'b1;
      else if (!wr && rd) count <= count - 1'b1;
      if (push && full && !pop_hit) err_overflow  <= 1'b1;
      if (pop_hit && empty)         err_underflow <= 1'b1;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (enb && wr) mem[wptr] <= din;
  end

endmodule

// File: rtl/banco_fifos.sv
// Bank of independent queues feeding the round-robin arbiter, popped by its selector.
// Latency: a pop in cycle N presents the word on data_out with data_out_vld in cycle N+1.
// Backpressure: per-queue full/almost_full status; overflowing pushes dropped and flagged.
module banco_fifos
  import banco_fifos_pkg::*;
#(
  parameter int QUEUE_QUANTITY = QUEUE_QUANTITY_DEF,
  parameter int DATA_BITS      = DATA_BITS_DEF,
  parameter int BUF_WIDTH      = BUF_WIDTH_DEF,
  parameter int ALMOST_FULL    = ALMOST_FULL_DEF,
  parameter int SEL_W          = $clog2(QUEUE_QUANTITY)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enb,
  input  logic [QUEUE_QUANTITY-1:0]           push,
  input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] data_in,
  input  logic                                pop,
  input  logic [SEL_W-1:0]                    pop_sel,
  output logic [DATA_BITS-1:0]                data_out,
  output logic                                data_out_vld,
  output logic [QUEUE_QUANTITY-1:0]           buf_empty,
  output logic [QUEUE_QUANTITY-1:0]           buf_full,
  output logic [QUEUE_QUANTITY-1:0]           almost_full,
  output logic [QUEUE_QUANTITY*BUF_WIDTH-1:0] fifo_counter,
  output logic [QUEUE_QUANTITY-1:0]           err_overflow,
  output logic [QUEUE_QUANTITY-1:0]           err_underflow
);

  logic [QUEUE_QUANTITY-1:0] pop_hit;
  logic [QUEUE_QUANTITY-1:0] rd_vld;
  logic [DATA_BITS-1:0]      rd_dat [QUEUE_QUANTITY];

  for (genvar i = 0; i < QUEUE_QUANTITY; i++) begin : g_cola
    assign pop_hit[i] = pop && (pop_sel == SEL_W'(i));

    fifo_cola #(
      .DATA_BITS  (DATA_BITS),
      .BUF_WIDTH  (BUF_WIDTH),
      .ALMOST_FULL(ALMOST_FULL)
    ) u_cola (
      .clk          (clk),
      .rst          (rst),
      .enb          (enb),
      .push         (push[i]),
      .din          (data_in[i*DATA_BITS +: DATA_BITS]),
      .pop_hit      (pop_hit[i]),
      .rd_dat       (rd_dat[i]),
      .rd_vld       (rd_vld[i]),
      .empty        (buf_empty[i]),
      .full         (buf_full[i]),
      .almost_full  (almost_full[i]),
      .count        (fifo_counter[i*BUF_WIDTH +: BUF_WIDTH]),
      .err_overflow (err_overflow[i]),
      .err_underflow(err_underflow[i])
    );
  end

  // Register the selected queue's head word; data_out holds when nothing valid was popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out     <= '0;
      data_out_vld <= 1'b0;
    end else if (enb) begin
      data_out_vld <= |rd_vld;
      if (|rd_vld) data_out <= rd_dat[pop_sel];
    end
  end

endmodule

// File: tb/tb_banco_fifos.sv
// Directed self-checking bench for banco_fifos (4 queues x 8 bits, 7 words each).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each task covers one scenario with hand-computed expected values.
module tb_banco_fifos;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [3:0]  push;
  logic [31:0] data_in;
  logic        pop;
  logic [1:0]  pop_sel;
  logic [7:0]  data_out;
  logic        data_out_vld;
  logic [3:0]  buf_empty;
  logic [3:0]  buf_full;
  logic [3:0]  almost_full;
  logic [11:0] fifo_counter;
  logic [3:0]  err_overflow;
  logic [3:0]  err_underflow;

  int checks = 0;
  int errors = 0;

  banco_fifos dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .pop_sel      (pop_sel),
    .data_out     (data_out),
    .data_out_vld (data_out_vld),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_full  (almost_full),
    .fifo_counter (fifo_counter),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] cnt(input int q);
    return fifo_counter[q*3 +: 3];
  endfunction

  task automatic idle();
    push = 4'b0000;
    pop  = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++; if (buf_empty !== 4'b1111) begin errors++; $display("FAIL rst_empty got %b want 1111", buf_empty); end
    checks++; if (fifo_counter !== 12'h000) begin errors++; $display("FAIL rst_counter got %h want 000", fifo_counter); end
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'h00) begin errors++; $display("FAIL rst_out got vld=%b dat=%h want 0/00", data_out_vld, data_out); end
    checks++; if (err_overflow !== 4'b0 || err_underflow !== 4'b0 || buf_full !== 4'b0 || almost_full !== 4'b0) begin
      errors++; $display("FAIL rst_flags got ov=%b un=%b full=%b af=%b want all 0", err_overflow, err_underflow, buf_full, almost_full);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push = 4'b0010;
      data_in[15:8] = 8'h11 + 8'(i);
      step();
    end
    checks++; if (cnt(1) !== 3'd3) begin errors++; $display("FAIL q1_count3 got %0d want 3", cnt(1)); end
    push = 4'b0000; pop = 1'b1; pop_sel = 2'd1;
    step();
    checks++; if (data_out_vld !== 1'b1 || data_out !== 8'h11 || cnt(1) !== 3'd2) begin
      errors++; $display("FAIL q1_pop got vld=%b dat=%h cnt=%0d want 1/11/2", data_out_vld, data_out, cnt(1));
    end
    pop = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if (fifo_counter !== 12'h000 || buf_empty !== 4'b1111) begin
      errors++; $display("FAIL async_rst got cnt=%h empty=%b want 000/1111", fifo_counter, buf_empty);
    end
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'h00) begin
      errors++; $display("FAIL async_rst_out got vld=%b dat=%h want 0/00", data_out_vld, data_out);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 7; i++) begin
      push = 4'b0100;
      data_in[23:16] = 8'hA0 + 8'(i);
      step();
      if (i == 4) begin
        checks++; if (almost_full[2] !== 1'b0) begin errors++; $display("FAIL af_at5 got %b want 0", almost_full[2]); end
      end
      if (i == 5) begin
        checks++; if (almost_full[2] !== 1'b1 || buf_full[2] !== 1'b0) begin
          errors++; $display("FAIL af_at6 got af=%b full=%b want 1/0", almost_full[2], buf_full[2]);
        end
      end
    end
    checks++; if (cnt(2) !== 3'd7 || buf_full !== 4'b0100 || almost_full !== 4'b0100) begin
      errors++; $display("FAIL q2_full got cnt=%0d full=%b af=%b want 7/0100/0100", cnt(2), buf_full, almost_full);
    end
    checks++; if (err_overflow !== 4'b0000) begin errors++; $display("FAIL no_ov_yet got %b want 0000", err_overflow); end
    data_in[23:16] = 8'hA7;
    step();
    idle();
    checks++; if (cnt(2) !== 3'd7 || err_overflow !== 4'b0100) begin
      errors++; $display("FAIL q2_overflow got cnt=%0d ov=%b want 7/0100", cnt(2), err_overflow);
    end
  endtask

  task automatic test_pop_order();
    pop = 1'b1; pop_sel = 2'd2;
    for (int i = 0; i < 7; i++) begin
      step();
      checks++; if (data_out_vld !== 1'b1 || data_out !== 8'hA0 + 8'(i)) begin
        errors++; $display("FAIL q2_pop%0d got vld=%b dat=%h want 1/%h", i, data_out_vld, data_out, 8'hA0 + 8'(i));
      end
    end
    pop = 1'b0;
    step();
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'hA6 || buf_empty[2] !== 1'b1 || err_underflow !== 4'b0) begin
      errors++; $display("FAIL q2_drained got vld=%b dat=%h empty=%b un=%b want 0/a6/1/0000", data_out_vld, data_out, buf_empty[2], err_underflow);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 7; i++) begin
      push = 4'b0001;
      data_in[7:0] = 8'h10 + 8'(i);
      step();
    end
    data_in[7:0] = 8'h55; pop = 1'b1; pop_sel = 2'd0;
    step();
    push = 4'b0000;
    checks++; if (cnt(0) !== 3'd7 || data_out !== 8'h10 || data_out_vld !== 1'b1 || err_overflow !== 4'b0100) begin
      errors++; $display("FAIL full_pushpop got cnt=%0d dat=%h vld=%b ov=%b want 7/10/1/0100", cnt(0), data_out, data_out_vld, err_overflow);
    end
    for (int i = 0; i < 7; i++) begin
      logic [7:0] exp;
      exp = (i == 6) ? 8'h55 : 8'h11 + 8'(i);
      step();
      checks++; if (data_out !== exp || data_out_vld !== 1'b1) begin
        errors++; $display("FAIL q0_pop%0d got dat=%h vld=%b want %h/1", i, data_out, data_out_vld, exp);
      end
    end
    pop = 1'b0;
    checks++; if (cnt(0) !== 3'd0 || buf_empty[0] !== 1'b1) begin
      errors++; $display("FAIL q0_empty got cnt=%0d empty=%b want 0/1", cnt(0), buf_empty[0]);
    end
  endtask

  task automatic test_underflow();
    push = 4'b1000; data_in[31:24] = 8'h33; pop = 1'b1; pop_sel = 2'd3;
    step();
    push = 4'b0000;
    checks++; if (err_underflow !== 4'b1000 || data_out_vld !== 1'b0 || cnt(3) !== 3'd1) begin
      errors++; $display("FAIL q3_underflow got un=%b vld=%b cnt=%0d want 1000/0/1", err_underflow, data_out_vld, cnt(3));
    end
    step();
    pop = 1'b0;
    checks++; if (data_out !== 8'h33 || data_out_vld !== 1'b1 || cnt(3) !== 3'd0) begin
      errors++; $display("FAIL q3_pop got dat=%h vld=%b cnt=%0d want 33/1/0", data_out, data_out_vld, cnt(3));
    end
  endtask

  task automatic test_enable();
    push = 4'b0001; data_in[7:0] = 8'h77;
    step();
    push = 4'b0000;
    checks++; if (data_out_vld !== 1'b0 || data_out !== 8'h33 || fifo_counter !== 12'h001) begin
      errors++; $display("FAIL pre_enb got vld=%b dat=%h cnt=%h want 0/33/001", data_out_vld, data_out, fifo_counter);
    end
    enb = 1'b0; push = 4'b1111; data_in = 32'hEEEE_EEEE; pop = 1'b1; pop_sel = 2'd0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (fifo_counter !== 12'h001 || buf_empty !== 4'b1110 || data_out_vld !== 1'b0 || data_out !== 8'h33) begin
      errors++; $display("FAIL enb_freeze got cnt=%h empty=%b vld=%b dat=%h want 001/1110/0/33", fifo_counter, buf_empty, data_out_vld, data_out);
    end
    checks++; if (err_overflow !== 4'b0100 || err_underflow !== 4'b1000) begin
      errors++; $display("FAIL enb_errs got ov=%b un=%b want 0100/1000", err_overflow, err_underflow);
    end
    enb = 1'b1; push = 4'b0000;
    step();
    pop = 1'b0;
    checks++; if (data_out !== 8'h77 || data_out_vld !== 1'b1 || cnt(0) !== 3'd0) begin
      errors++; $display("FAIL enb_resume got dat=%h vld=%b cnt=%0d want 77/1/0", data_out, data_out_vld, cnt(0));
    end
  endtask

  task automatic test_wrap();
    pop_sel = 2'd1;
    for (int i = 0; i < 20; i++) begin
      push = 4'b0010;
      data_in[15:8] = 8'hC0 + 8'(i);
      pop = (i != 0);
      step();
      if (i != 0) begin
        checks++; if (data_out !== 8'hC0 + 8'(i - 1) || data_out_vld !== 1'b1 || cnt(1) !== 3'd1) begin
          errors++; $display("FAIL wrap%0d got dat=%h vld=%b cnt=%0d want %h/1/1", i, data_out, data_out_vld, cnt(1), 8'hC0 + 8'(i - 1));
        end
      end
    end
    push = 4'b0000; pop = 1'b1;
    step();
    pop = 1'b0;
    checks++; if (data_out !== 8'hD3 || data_out_vld !== 1'b1 || buf_empty !== 4'b1111) begin
      errors++; $display("FAIL wrap_last got dat=%h vld=%b empty=%b want d3/1/1111", data_out, data_out_vld, buf_empty);
    end
  endtask

  initial begin
    rst = 1'b0; enb = 1'b1; push = 4'b0000; data_in = 32'h0; pop = 1'b0; pop_sel = 2'd0;
    test_reset();
    test_overflow();
    test_pop_order();
    test_full_push_pop();
    test_underflow();
    test_enable();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
